// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state encoding, the widest supported operand and the product negation helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_WIDTH_MAX = 32;

    // Two's-complement negation at the widest product width; callers keep the low bits they need.
    function automatic logic [2*MULT_WIDTH_MAX-1:0] twos_neg(input logic [2*MULT_WIDTH_MAX-1:0] v);
        return ~v + (2*MULT_WIDTH_MAX)'(1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the ripple-carry adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mult_ripple_adder.sv
// N-bit ripple-carry adder built from a chain of full_adder cells.
module mult_ripple_adder #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[N];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 shift-add multiplier: one partial product per cycle over WIDTH cycles,
// operating on magnitudes and negating the finished product when the operand signs differ.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   mag_a, mag_b, acc_hi, acc_lo;
    logic               neg;
    logic [2*WIDTH-1:0] out_p_r;

    logic [WIDTH-1:0]   a_mag, b_mag, addend;
    logic [WIDTH:0]     sum;
    logic               add_cout;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] final_acc, product;
    logic [2*MULT_WIDTH_MAX-1:0] neg_full;
    logic               unused_bits;

    // The magnitude of the most negative value still fits in WIDTH unsigned bits.
    assign a_mag  = (in_signed && in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
    assign b_mag  = (in_signed && in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;
    assign addend = mag_b[0] ? mag_a : '0;

    mult_ripple_adder #(.N(WIDTH + 1)) u_add (
        .a    ({1'b0, acc_hi}),
        .b    ({1'b0, addend}),
        .cin  (1'b0),
        .sum  (sum),
        .cout (add_cout)
    );

    assign step_hi     = sum[WIDTH:1];
    assign step_lo     = {sum[0], acc_lo[WIDTH-1:1]};
    assign final_acc   = {step_hi, step_lo};
    assign neg_full    = twos_neg((2*MULT_WIDTH_MAX)'(final_acc));
    assign product     = neg ? neg_full[2*WIDTH-1:0] : final_acc;
    assign unused_bits = ^{neg_full, add_cout};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (count == LAST_STEP) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg     <= 1'b0;
            out_p_r <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mag_a  <= a_mag;
                    mag_b  <= b_mag;
                    neg    <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    acc_hi <= '0;
                    acc_lo <= '0;
                    count  <= '0;
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    mag_b  <= mag_b >> 1;
                    count  <= count + CNT_W'(1);
                    if (count == LAST_STEP) out_p_r <= product;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_p     = out_p_r;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier at WIDTH=4 and WIDTH=8 with a queue-based scoreboard.
module tb_seq_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid4 = 1'b0, in_signed4 = 1'b0, out_ready4 = 1'b1;
    logic [3:0] in_a4 = '0, in_b4 = '0;
    logic       in_ready4, out_valid4, busy4;
    logic [7:0] out_p4;

    logic        in_valid8 = 1'b0, in_signed8 = 1'b0, out_ready8 = 1'b1;
    logic [7:0]  in_a8 = '0, in_b8 = '0;
    logic        in_ready8, out_valid8, busy8;
    logic [15:0] out_p8;

    logic [7:0]  exp_q4[$];
    logic [15:0] exp_q8[$];
    int          busy_runs8[$];
    int          run8 = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_signed(in_signed4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_p(out_p4), .busy(busy4)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_signed(in_signed8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_p(out_p8), .busy(busy8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: a product is consumed at the edge after a negedge where valid & ready.
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            if (exp_q4.size() == 0) check("w4_unexpected_product", {56'd0, out_p4}, 64'hDEAD);
            else check("w4_product", {56'd0, out_p4}, {56'd0, exp_q4.pop_front()});
        end
        if (rst_n && out_valid8 && out_ready8) begin
            if (exp_q8.size() == 0) check("w8_unexpected_product", {48'd0, out_p8}, 64'hDEAD);
            else check("w8_product", {48'd0, out_p8}, {48'd0, exp_q8.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (busy8) run8++;
        else if (run8 > 0) begin
            busy_runs8.push_back(run8);
            run8 = 0;
        end
    end

    task automatic wait_ready4();
        int n = 0;
        while (!in_ready4 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 60) check("w4_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_ready8();
        int n = 0;
        while (!in_ready8 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 60) check("w8_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic [7:0] exp, input bit push, input bit chk_lat);
        int n = 0;
        wait_ready4();
        in_valid4 = 1'b1; in_a4 = a; in_b4 = b; in_signed4 = s;
        if (push) exp_q4.push_back(exp);
        @(posedge clk); #1;
        // Scramble the operand bus while running; it must be ignored.
        in_valid4 = 1'b0; in_a4 = 4'($urandom_range(0, 15)); in_b4 = 4'($urandom_range(0, 15));
        in_signed4 = 1'($urandom_range(0, 1));
        if (chk_lat) begin
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid4 && n < 30);
            check("w4_latency", 64'(n - 1), 64'd4);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
        wait_ready8();
        in_valid8 = 1'b1; in_a8 = a; in_b8 = b; in_signed8 = s;
        exp_q8.push_back(exp);
        @(posedge clk); #1;
        in_valid8 = 1'b0; in_a8 = 8'($urandom_range(0, 255)); in_b8 = 8'($urandom_range(0, 255));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q4.size() != 0 || exp_q8.size() != 0 || !in_ready4 || !in_ready8) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        // Reset state.
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready4}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid4}, 64'd0);
        check("rst_out_p", {56'd0, out_p4}, 64'd0);
        check("rst_busy", {63'd0, busy4}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned 13*11 with latency check, then signed/unsigned corners.
        op4(4'hD, 4'hB, 1'b0, 8'h8F, 1'b1, 1'b1);
        op4(4'h8, 4'h8, 1'b1, 8'h40, 1'b1, 1'b0);
        op4(4'h8, 4'h8, 1'b0, 8'h40, 1'b1, 1'b0);
        op4(4'hD, 4'h5, 1'b1, 8'hF1, 1'b1, 1'b0);
        op4(4'h0, 4'hF, 1'b1, 8'h00, 1'b1, 1'b0);
        op4(4'hF, 4'hF, 1'b0, 8'hE1, 1'b1, 1'b0);
        op4(4'h7, 4'h8, 1'b1, 8'hC8, 1'b1, 1'b0);
        drain();

        // Backpressure: 7*6 held for 10 cycles with out_ready low.
        out_ready4 = 1'b0;
        op4(4'h7, 4'h6, 1'b0, 8'h2A, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", {63'd0, out_valid4}, 64'd1);
            check("bp_out_p", {56'd0, out_p4}, 64'h2A);
            check("bp_in_ready", {63'd0, in_ready4}, 64'd0);
            if (i < 9) @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", {63'd0, in_ready4}, 64'd1);
        check("bp_release_out_valid", {63'd0, out_valid4}, 64'd0);
        check("bp_out_p_kept", {56'd0, out_p4}, 64'h2A);

        // Reset two cycles into RUN aborts the operation.
        op4(4'h5, 4'h7, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("mid_busy_before_reset", {63'd0, busy4}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid4}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready4}, 64'd1);
        check("mid_rst_busy", {63'd0, busy4}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op4(4'h2, 4'h3, 1'b0, 8'h06, 1'b1, 1'b1);
        drain();

        // WIDTH=8 corners issued back to back.
        repeat (3) @(negedge clk);
        busy_runs8.delete();
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        op8(8'h80, 8'h7F, 1'b1, 16'hC080);
        op8(8'h80, 8'h80, 1'b1, 16'h4000);
        drain();
        repeat (3) @(negedge clk);
        check("w8_busy_run_count", 64'(busy_runs8.size()), 64'd3);
        while (busy_runs8.size() != 0) check("w8_busy_run_len", 64'(busy_runs8.pop_front()), 64'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
